// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - Shared types and constants for the timer_counter block
// Contents: FSM state enum, register offsets, CTRL bit positions, mode codes,
//           prescale field width, and the auto-reload mode decode helper.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } tc_state_e;

    localparam logic [1:0] OFF_CTRL   = 2'b00;
    localparam logic [1:0] OFF_PRESET = 2'b01;
    localparam logic [1:0] OFF_COUNT  = 2'b10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PS_LO   = 4;

    localparam int PRESCALE_W = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only 01 reloads; 00 and both 1x codes behave as one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - Bridge-side register bus for timer_counter
// Signals: addr[29:0] word address, we write strobe, wdata[31:0],
//          rdata[31:0] combinational read data, irq interrupt request.
// Modports: master (bridge side), slave (timer side).
interface timer_counter_if;
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, output we, output wdata, input rdata, input irq);
    modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/tc_prescaler.sv
// rtl/tc_prescaler.sv - Tick generator pulsing once every 2^p cycles
// Ports: clk, reset (sync, active-low), clr (restart count), p (exponent),
//        tick (high for one cycle each time the low p bits of the counter wrap).
// Used only when TC_PRESCALE_EN is defined.
module tc_prescaler
    import tc_pkg::*;
#(
    parameter int PS_W = PRESCALE_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic [PS_W-1:0] p,
    output logic            tick
);
    // Wide enough for the largest exponent; its full wrap is a multiple of every 2^p.
    localparam int CNT_W = (1 << PS_W) - 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] mask;

    // p = 0 gives an empty mask, so tick is permanently high.
    assign mask = ~({CNT_W{1'b1}} << p);
    assign tick = (cnt_q & mask) == mask;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - Memory-mapped 32-bit down-counting timer with interrupt
// Ports: clk, reset (sync, active-low, 0 = reset),
//        bus (timer_counter_if.slave: addr, we, wdata in; rdata, irq out).
// Registers (addr[1:0]): 00 CTRL {IM,MODE,EN}, 01 PRESET, 10 COUNT (RO), 11 reserved.
// Optional macro TC_PRESCALE_EN: CTRL[3+PRESCALE_W:4] prescale exponent.
module timer_counter
    import tc_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);
    tc_state_e   state_q, state_d;
    logic        ctrl_en_q;
    logic [1:0]  ctrl_mode_q;
    logic        ctrl_im_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;
    logic        irq_q;

    logic        ctrl_wr, preset_wr;
    logic        tick;
    logic        do_load, do_dec, do_expire, int_oneshot, int_reload;
    logic [31:0] ctrl_rd;
    logic [31:0] rdata_c;
    logic        unused_addr;

    // Window selection is done by the bridge; only the register offset matters here.
    assign unused_addr = ^bus.addr[29:2];

    assign ctrl_wr   = bus.we && (bus.addr[1:0] == OFF_CTRL);
    assign preset_wr = bus.we && (bus.addr[1:0] == OFF_PRESET);

`ifdef TC_PRESCALE_EN
    logic [PRESCALE_W-1:0] ctrl_ps_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_ps_q <= '0;
        end else if (ctrl_wr) begin
            ctrl_ps_q <= bus.wdata[CTRL_PS_LO +: PRESCALE_W];
        end
    end

    tc_prescaler #(.PS_W(PRESCALE_W)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (ctrl_wr || (state_q == ST_LOAD)),
        .p     (ctrl_ps_q),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ctrl_en_q) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_CNT;
            ST_CNT: begin
                if (!ctrl_en_q) begin
                    state_d = ST_IDLE;
                end else if (tick && (count_q <= 32'd1)) begin
                    state_d = ST_INT;
                end
            end
            ST_INT:  state_d = is_reload(ctrl_mode_q) ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        do_load     = 1'b0;
        do_dec      = 1'b0;
        do_expire   = 1'b0;
        int_oneshot = 1'b0;
        int_reload  = 1'b0;
        case (state_q)
            ST_LOAD: do_load = 1'b1;
            ST_CNT: begin
                if (ctrl_en_q && tick) begin
                    if (count_q > 32'd1) begin
                        do_dec = 1'b1;
                    end else begin
                        do_expire = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (is_reload(ctrl_mode_q)) begin
                    int_reload = 1'b1;
                end else begin
                    int_oneshot = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A CPU write to CTRL overrides the one-shot EN auto-clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= MODE_ONESHOT;
            ctrl_im_q   <= 1'b0;
            preset_q    <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en_q   <= bus.wdata[CTRL_EN];
                ctrl_mode_q <= bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO];
                ctrl_im_q   <= bus.wdata[CTRL_IM];
            end else if (int_oneshot) begin
                ctrl_en_q <= 1'b0;
            end
            if (preset_wr) begin
                preset_q <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (do_load) begin
            count_q <= preset_q;
        end else if (do_dec) begin
            count_q <= count_q - 32'd1;
        end else if (do_expire) begin
            count_q <= '0;
        end
    end

    // Expiry sets the flag even if CTRL is written in the same cycle so the event is not lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (do_expire) begin
                irq_flag_q <= 1'b1;
            end else if (ctrl_wr || int_reload) begin
                irq_flag_q <= 1'b0;
            end
            irq_q <= irq_flag_q & ctrl_im_q;
        end
    end

    always_comb begin
        ctrl_rd                             = '0;
        ctrl_rd[CTRL_EN]                    = ctrl_en_q;
        ctrl_rd[CTRL_MODE_HI:CTRL_MODE_LO]  = ctrl_mode_q;
        ctrl_rd[CTRL_IM]                    = ctrl_im_q;
`ifdef TC_PRESCALE_EN
        ctrl_rd[CTRL_PS_LO +: PRESCALE_W]   = ctrl_ps_q;
`endif
    end

    always_comb begin
        rdata_c = '0;
        case (bus.addr[1:0])
            OFF_CTRL:   rdata_c = ctrl_rd;
            OFF_PRESET: rdata_c = preset_q;
            OFF_COUNT:  rdata_c = count_q;
            default:    rdata_c = '0;
        endcase
    end

    assign bus.rdata = rdata_c;
    assign bus.irq   = irq_q;
endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - Scoreboard testbench for timer_counter
module tb_timer_counter;
    import tc_pkg::*;

    localparam logic [29:0] BASE = 30'h0000_1FC0;
    localparam logic [1:0]  OFF_RSVD = 2'b11;

    logic clk = 1'b0;
    logic reset;

    timer_counter_if bus_if ();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_irq;
        logic        exp_irq;
        logic        chk_flag;
        logic        exp_flag;
        logic        chk_idle;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] os_exp [9]  = '{0, 0, 5, 4, 3, 2, 1, 0, 0};
    logic [31:0] ar_exp [13] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
    logic [31:0] ps_exp [9]  = '{2, 2, 2, 2, 1, 1, 1, 1, 0};

    always begin
        @(sample_ev);
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk_rd) begin
                checks++;
                if (bus_if.rdata !== mon_e.exp_rd) begin
                    errors++;
                    $display("FAIL %s rdata got=%h exp=%h", mon_e.name, bus_if.rdata, mon_e.exp_rd);
                end
            end
            if (mon_e.chk_irq) begin
                checks++;
                if (bus_if.irq !== mon_e.exp_irq) begin
                    errors++;
                    $display("FAIL %s irq got=%b exp=%b", mon_e.name, bus_if.irq, mon_e.exp_irq);
                end
            end
            if (mon_e.chk_flag) begin
                checks++;
                if (dut.irq_flag_q !== mon_e.exp_flag) begin
                    errors++;
                    $display("FAIL %s irq_flag got=%b exp=%b", mon_e.name, dut.irq_flag_q, mon_e.exp_flag);
                end
            end
            if (mon_e.chk_idle) begin
                checks++;
                if (dut.state_q != ST_IDLE) begin
                    errors++;
                    $display("FAIL %s state got=%0d exp=IDLE", mon_e.name, dut.state_q);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.addr  = BASE | {28'd0, a};
        bus_if.wdata = d;
        bus_if.we    = 1'b1;
        step();
        bus_if.we    = 1'b0;
    endtask

    task automatic post(input exp_t e);
        sb_q.push_back(e);
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] a, input logic [31:0] exp_rd,
                       input logic ci, input logic ei);
        exp_t e;
        e.name = name; e.chk_rd = 1'b1; e.exp_rd = exp_rd;
        e.chk_irq = ci; e.exp_irq = ei;
        e.chk_flag = 1'b0; e.exp_flag = 1'b0; e.chk_idle = 1'b0;
        bus_if.addr = BASE | {28'd0, a};
        post(e);
    endtask

    task automatic chk_int(input string name, input logic cf, input logic ef, input logic ci);
        exp_t e;
        e.name = name; e.chk_rd = 1'b0; e.exp_rd = '0;
        e.chk_irq = 1'b0; e.exp_irq = 1'b0;
        e.chk_flag = cf; e.exp_flag = ef; e.chk_idle = ci;
        post(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
        step(); step();
        reset = 1'b1;

        // Reset mid-count with a CTRL write pending: reset must win.
        wr(OFF_PRESET, 32'h1234_5678);
        wr(OFF_CTRL, 32'h0000_000B);
        repeat (3) step();
        reset = 1'b0;
        bus_if.addr = BASE | {28'd0, OFF_CTRL}; bus_if.wdata = 32'hF; bus_if.we = 1'b1;
        step(); step();
        reset = 1'b1; bus_if.we = 1'b0;
        chk("rst_ctrl", OFF_CTRL, 32'h0, 1'b1, 1'b0);
        chk("rst_preset", OFF_PRESET, 32'h0, 1'b0, 1'b0);
        chk("rst_count", OFF_COUNT, 32'h0, 1'b0, 1'b0);
        chk_int("rst_int", 1'b1, 1'b0, 1'b1);
        step(); step();
        chk("rst_idle_count", OFF_COUNT, 32'h0, 1'b1, 1'b0);

        // One-shot, PRESET=5.
        wr(OFF_PRESET, 32'd5);
        wr(OFF_CTRL, 32'h9);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("os_e%0d", k), OFF_COUNT, os_exp[k], 1'b1, k >= 8);
            if (k < 8) step();
        end
        chk("os_en_clr", OFF_CTRL, 32'h8, 1'b1, 1'b1);
        step(); step();
        chk("os_irq_hold", OFF_COUNT, 32'h0, 1'b1, 1'b1);
        wr(OFF_CTRL, 32'h8);
        chk("os_ack_edge", OFF_CTRL, 32'h8, 1'b1, 1'b1);
        step();
        chk("os_ack_drop", OFF_CTRL, 32'h8, 1'b1, 1'b0);

        // Auto-reload, PRESET=3: 5-cycle period, 1-cycle irq pulse.
        wr(OFF_PRESET, 32'd3);
        wr(OFF_CTRL, 32'hB);
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("ar_e%0d", k), OFF_COUNT, ar_exp[k], 1'b1, (k == 6) || (k == 11));
            if (k < 12) step();
        end
        wr(OFF_CTRL, 32'h8);
        step();
        chk("ar_stop", OFF_COUNT, 32'd2, 1'b1, 1'b0);
        chk_int("ar_stop_int", 1'b1, 1'b0, 1'b1);

        // Stop mid-count and restart from PRESET.
        wr(OFF_PRESET, 32'd100);
        wr(OFF_CTRL, 32'h9);
        repeat (62) step();
        chk("mid_40", OFF_COUNT, 32'd40, 1'b1, 1'b0);
        wr(OFF_CTRL, 32'h8);
        chk("mid_stop", OFF_COUNT, 32'd39, 1'b0, 1'b0);
        repeat (3) step();
        chk("mid_frozen", OFF_COUNT, 32'd39, 1'b1, 1'b0);
        chk_int("mid_idle", 1'b1, 1'b0, 1'b1);
        wr(OFF_CTRL, 32'h9);
        step(); step();
        chk("mid_restart", OFF_COUNT, 32'd100, 1'b0, 1'b0);
        step();
        chk("mid_dec", OFF_COUNT, 32'd99, 1'b0, 1'b0);
        wr(OFF_CTRL, 32'h0);
        step();
        chk("mid_stop2", OFF_COUNT, 32'd98, 1'b1, 1'b0);

        // IM=0, PRESET=0: flag sets internally but irq stays low.
        wr(OFF_PRESET, 32'd0);
        wr(OFF_CTRL, 32'h1);
        repeat (4) step();
        chk("mask_count", OFF_COUNT, 32'd0, 1'b1, 1'b0);
        chk("mask_en_clr", OFF_CTRL, 32'd0, 1'b0, 1'b0);
        chk_int("mask_flag", 1'b1, 1'b1, 1'b1);
        step(); step();
        chk("mask_irq_low", OFF_COUNT, 32'd0, 1'b1, 1'b0);
        wr(OFF_CTRL, 32'h8);
        step();
        chk("mask_wr_irq", OFF_CTRL, 32'h8, 1'b1, 1'b0);
        chk_int("mask_wr_flag", 1'b1, 1'b0, 1'b0);

        // Writes to COUNT and reserved are ignored.
        wr(OFF_COUNT, 32'hDEAD_BEEF);
        chk("count_ro", OFF_COUNT, 32'd0, 1'b0, 1'b0);
        wr(OFF_RSVD, 32'hFFFF_FFFF);
        chk("rsvd_zero", OFF_RSVD, 32'd0, 1'b0, 1'b0);
        wr(OFF_PRESET, 32'hA5A5_5A5A);
        chk("preset_rw", OFF_PRESET, 32'hA5A5_5A5A, 1'b0, 1'b0);

        // MODE=10 behaves as one-shot.
        wr(OFF_PRESET, 32'd1);
        wr(OFF_CTRL, 32'hD);
        repeat (4) step();
        chk("m10_en_clr", OFF_CTRL, 32'hC, 1'b1, 1'b1);
        chk("m10_count", OFF_COUNT, 32'd0, 1'b0, 1'b0);
        chk_int("m10_idle", 1'b0, 1'b0, 1'b1);
        wr(OFF_CTRL, 32'h8);
        step();

        // CPU CTRL write while in INT: written value wins, flag cleared.
        wr(OFF_PRESET, 32'd0);
        wr(OFF_CTRL, 32'h9);
        repeat (3) step();
        chk_int("col_flag_set", 1'b1, 1'b1, 1'b0);
        wr(OFF_CTRL, 32'hB);
        chk("col_ctrl", OFF_CTRL, 32'hB, 1'b1, 1'b1);
        chk_int("col_flag_clr", 1'b1, 1'b0, 1'b0);
        step();
        chk("col_irq_drop", OFF_CTRL, 32'hB, 1'b1, 1'b0);
        wr(OFF_CTRL, 32'h0);
        step();

        // CTRL upper bits.
        wr(OFF_CTRL, 32'hFFFF_FFFF);
`ifdef TC_PRESCALE_EN
        chk("ctrl_ones", OFF_CTRL, 32'h7F, 1'b0, 1'b0);
`else
        chk("ctrl_ones", OFF_CTRL, 32'hF, 1'b0, 1'b0);
`endif
        wr(OFF_CTRL, 32'h0);
        step(); step();
        chk_int("ones_idle", 1'b0, 1'b0, 1'b1);

`ifdef TC_PRESCALE_EN
        // P=2, reload: COUNT steps every 4 cycles.
        wr(OFF_PRESET, 32'd2);
        wr(OFF_CTRL, 32'h2B);
        step(); step();
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("ps_e%0d", k + 2), OFF_COUNT, ps_exp[k], 1'b0, 1'b0);
            if (k < 8) step();
        end
        wr(OFF_CTRL, 32'h0);
        step();
`endif

        step(); step();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending got=%0d exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
